// File: rtl/frogger_pkg.sv
// Shared frogger encodings: move directions, input-controller FSM states, default 25 MHz timing.
// Pure declarations, no latency or flow control of its own.
package frogger_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int DEF_REPEAT_DELAY_CYCLES = 12500000;
  localparam int DEF_REPEAT_RATE_CYCLES  = 3750000;
  localparam int DEF_CHORD_HOLD_CYCLES   = 25000000;
  localparam int DEF_CNT_W               = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD_DELAY,
    ST_REPEAT,
    ST_CHORD,
    ST_RELEASE_WAIT
  } state_t;

  // Only meaningful for a one-hot button vector.
  function automatic logic [1:0] enc_dir(input logic [3:0] buttons);
    logic [1:0] dir;
    dir = DIR_UP;
    if (buttons[1]) dir = DIR_DOWN;
    else if (buttons[2]) dir = DIR_LEFT;
    else if (buttons[3]) dir = DIR_RIGHT;
    return dir;
  endfunction

endpackage

// File: rtl/frogger_input_ctrl_move_slot.sv
// One-deep valid/ready holding register: a request shows on o_Vld one cycle later.
// Requests arriving while the slot is full and not being drained are dropped; o_Dat holds steady.
module move_slot #(
  parameter int W = 2
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Req_Vld,
  input  logic [W-1:0] i_Req_Dat,
  input  logic         i_Rdy,
  output logic         o_Vld,
  output logic [W-1:0] o_Dat
);

  logic         r_Vld;
  logic [W-1:0] r_Dat;
  logic         w_Load;

  assign w_Load = i_Req_Vld & (~r_Vld | i_Rdy);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Vld <= 1'b0;
      r_Dat <= '0;
    end else if (w_Load) begin
      r_Vld <= 1'b1;
      r_Dat <= i_Req_Dat;
    end else if (i_Rdy) begin
      r_Vld <= 1'b0;
    end
  end

  assign o_Vld = r_Vld;
  assign o_Dat = r_Dat;

endmodule

// File: rtl/frogger_input_ctrl.sv
// Buttons -> move commands (press edge to o_Move_Valid = 1 cycle) and held 4-button chord -> one-cycle game start.
// Moves requested while one is stalled are dropped; hold-to-repeat only when FROGGER_AUTO_REPEAT_EN is defined.
module frogger_input_ctrl
  import frogger_pkg::*;
#(
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter int CHORD_HOLD_CYCLES   = DEF_CHORD_HOLD_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [3:0] i_Buttons,
  input  logic       i_Move_Ready,
  output logic       o_Move_Valid,
  output logic [1:0] o_Move_Dir,
  output logic       o_Game_Start,
  output logic       o_Chord_Active
);

  localparam logic [CNT_W-1:0] LP_CHORD_LOAD = CNT_W'(CHORD_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE    = CNT_W'(1);
`ifdef FROGGER_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] LP_DELAY_LOAD = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_RATE_LOAD  = CNT_W'(REPEAT_RATE_CYCLES - 1);
`endif

  state_t           r_State;
  state_t           w_State_Nxt;
  logic [CNT_W-1:0] r_Cnt;
  logic [CNT_W-1:0] w_Cnt_Nxt;
  logic [3:0]       r_Buttons_Prev;
  logic             r_Armed;
  logic             r_Game_Start;
  logic             w_Single;
  logic             w_All4;
  logic             w_None;
  logic             w_Rise;
  logic             w_Move_Req;
  logic             w_Start;
  logic [1:0]       w_Move_Dir;
`ifdef FROGGER_AUTO_REPEAT_EN
  logic             w_Change;
  assign w_Change = (i_Buttons != r_Buttons_Prev);
`endif

  assign w_Single   = $onehot(i_Buttons);
  assign w_All4     = (i_Buttons == 4'b1111);
  assign w_None     = (i_Buttons == 4'b0000);
  assign w_Rise     = |(i_Buttons & ~r_Buttons_Prev);
  assign w_Move_Dir = enc_dir(i_Buttons);

  // r_Armed masks the first cycle after reset so a button held through reset is not seen as a fresh press.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State        <= ST_IDLE;
      r_Cnt          <= '0;
      r_Buttons_Prev <= 4'b0000;
      r_Armed        <= 1'b0;
      r_Game_Start   <= 1'b0;
    end else begin
      r_State        <= w_State_Nxt;
      r_Cnt          <= w_Cnt_Nxt;
      r_Buttons_Prev <= i_Buttons;
      r_Armed        <= 1'b1;
      r_Game_Start   <= w_Start;
    end
  end

  always_comb begin
    w_State_Nxt = r_State;
    w_Cnt_Nxt   = r_Cnt;
    w_Move_Req  = 1'b0;
    w_Start     = 1'b0;
    if (w_All4 && (r_State != ST_CHORD)) begin
      w_State_Nxt = ST_CHORD;
      w_Cnt_Nxt   = LP_CHORD_LOAD;
    end else begin
      case (r_State)
        ST_IDLE: begin
          if (w_Single && w_Rise && r_Armed) begin
            w_Move_Req = 1'b1;
`ifdef FROGGER_AUTO_REPEAT_EN
            w_State_Nxt = ST_HOLD_DELAY;
            w_Cnt_Nxt   = LP_DELAY_LOAD;
`else
            w_State_Nxt = ST_RELEASE_WAIT;
`endif
          end
        end
`ifdef FROGGER_AUTO_REPEAT_EN
        ST_HOLD_DELAY, ST_REPEAT: begin
          if (w_Change) begin
            w_State_Nxt = ST_IDLE;
          end else if (r_Cnt == '0) begin
            w_Move_Req  = 1'b1;
            w_State_Nxt = ST_REPEAT;
            w_Cnt_Nxt   = LP_RATE_LOAD;
          end else begin
            w_Cnt_Nxt = r_Cnt - LP_CNT_ONE;
          end
        end
`endif
        ST_CHORD: begin
          if (!w_All4) begin
            w_State_Nxt = ST_IDLE;
          end else if (r_Cnt == '0) begin
            w_Start     = 1'b1;
            w_State_Nxt = ST_RELEASE_WAIT;
          end else begin
            w_Cnt_Nxt = r_Cnt - LP_CNT_ONE;
          end
        end
        ST_RELEASE_WAIT: begin
          if (w_None) w_State_Nxt = ST_IDLE;
        end
        default: w_State_Nxt = ST_IDLE;
      endcase
    end
  end

  move_slot #(.W(2)) u_move_slot (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_Req_Vld (w_Move_Req),
    .i_Req_Dat (w_Move_Dir),
    .i_Rdy     (i_Move_Ready),
    .o_Vld     (o_Move_Valid),
    .o_Dat     (o_Move_Dir)
  );

  assign o_Game_Start   = r_Game_Start;
  assign o_Chord_Active = (r_State == ST_CHORD) & w_All4;

endmodule
